// File: rtl/seq_pkg.sv
// Shared state encoding and next-PC source codes for the multi-cycle sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    ERR       = 3'd6
  } seq_state_t;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b10;

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-ack wait counter: counts stalled request cycles and flags the cycle
// on which the wait limit is reached.
module seq_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (waiting) cnt <= cnt + 1'b1;
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign expired = waiting && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/writeback, one instruction
// at a time. Optional ack timeout with sticky bus_err under SEQ_TIMEOUT_EN.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 Load,
  input  logic                 Store,
  input  logic                 Branch,
  input  logic                 next_sel,
  input  logic                 Jalr,
  input  logic                 branch_result,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 ir_load,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_write_en,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 bus_err
);

  seq_state_t state, state_next;
  logic       retire;
  logic       expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      instret <= '0;
    end else begin
      state <= state_next;
      if (retire) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write_en = 1'b0;
    pc_sel       = PC_PLUS4;
    retire       = 1'b0;
    case (state)
      IDLE:    if (run) state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE:  state_next = EXECUTE;
      EXECUTE: begin
        // Load/Store wins over Branch if decode ever sets both.
        if (Load || Store) state_next = MEM;
        else if (Branch) begin
          retire = 1'b1;
          pc_sel = branch_result ? PC_TARGET : PC_PLUS4;
        end else state_next = WRITEBACK;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = Store;
        if (dmem_ack) begin
          if (Store) retire = 1'b1;
          else       state_next = WRITEBACK;
        end
      end
      WRITEBACK: begin
        reg_write_en = 1'b1;
        retire       = 1'b1;
        pc_sel       = next_sel ? PC_TARGET : (Jalr ? PC_JALR : PC_PLUS4);
      end
`ifdef SEQ_TIMEOUT_EN
      ERR:     state_next = ERR;
`endif
      default: state_next = IDLE;
    endcase
    if (retire) state_next = run ? FETCH : IDLE;
`ifdef SEQ_TIMEOUT_EN
    if (expired) state_next = ERR;
`endif
  end

  assign pc_en = retire;
  assign busy  = (state != IDLE);

`ifdef SEQ_TIMEOUT_EN
  logic waiting;
  assign waiting = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);

  // Any state change (including FETCH/MEM entry) restarts the wait count.
  seq_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_next != state),
    .waiting (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         bus_err <= 1'b0;
    else if (expired) bus_err <= 1'b1;
  end
`else
  assign expired = 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed table-driven bench for multicycle_sequencer plus hand sequences for
// back-to-back issue, mid-instruction reset and (with SEQ_TIMEOUT_EN) timeout.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, Load, Store, Branch, next_sel, Jalr, branch_result;
  logic        imem_ack, dmem_ack;
  logic        imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_en, busy, bus_err;
  logic [1:0]  pc_sel;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;
  int exp_instret = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.CNT_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .run(run), .Load(Load), .Store(Store), .Branch(Branch),
    .next_sel(next_sel), .Jalr(Jalr), .branch_result(branch_result),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_load(ir_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write_en(reg_write_en), .pc_en(pc_en),
    .pc_sel(pc_sel), .busy(busy), .instret(instret), .bus_err(bus_err)
  );

  typedef struct {
    string      name;
    logic       ld, st, br, jal, jalr, bres;
    int         idly, ddly;
    bit         spur;
    int         pc_cyc;
    logic [1:0] sel;
    int         rwe_cyc;
    int         dreq;
    logic       we;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string n, logic ld, logic st, logic br, logic jal, logic jalr,
                              logic bres, int idly, int ddly, bit spur, int pc_cyc,
                              logic [1:0] sel, int rwe_cyc, int dreq, logic we);
    vec_t v;
    v.name = n; v.ld = ld; v.st = st; v.br = br; v.jal = jal; v.jalr = jalr; v.bres = bres;
    v.idly = idly; v.ddly = ddly; v.spur = spur; v.pc_cyc = pc_cyc; v.sel = sel;
    v.rwe_cyc = rwe_cyc; v.dreq = dreq; v.we = we;
    return v;
  endfunction

  // Runs one instruction from IDLE; run drops in DECODE so it ends in IDLE.
  task automatic run_vec(input vec_t v);
    int ir_cyc = 0, ireq = 0, dreq = 0, rwe_cyc = 0, pc_cyc = 0, selbad = 0;
    logic [1:0] sel = 2'b00;
    logic we = 1'b0;
    @(negedge clk);
    Load = v.ld; Store = v.st; Branch = v.br; next_sel = v.jal; Jalr = v.jalr;
    branch_result = v.bres; run = 1'b1;
    for (int c = 1; c <= 40 && pc_cyc == 0; c++) begin
      @(negedge clk);
      if (c >= 2) run = 1'b0;
      imem_ack = imem_req ? (ireq >= v.idly) : v.spur;
      dmem_ack = dmem_req ? (dreq >= v.ddly) : v.spur;
      #1;
      if (imem_req) ireq++;
      if (ir_load) ir_cyc = c;
      if (dmem_req) begin dreq++; we |= dmem_we; end
      if (reg_write_en) rwe_cyc = c;
      if (pc_en) begin pc_cyc = c; sel = pc_sel; end
      else if (pc_sel != 2'b00) selbad++;
    end
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    exp_instret++;
    chk({v.name, ".pc_cyc"},  pc_cyc,  v.pc_cyc);
    chk({v.name, ".pc_sel"},  sel,     v.sel);
    chk({v.name, ".rwe_cyc"}, rwe_cyc, v.rwe_cyc);
    chk({v.name, ".dreq"},    dreq,    v.dreq);
    chk({v.name, ".dmem_we"}, we,      v.we);
    chk({v.name, ".ireq"},    ireq,    v.idly + 1);
    chk({v.name, ".ir_cyc"},  ir_cyc,  v.idly + 1);
    chk({v.name, ".selbad"},  selbad,  0);
    chk({v.name, ".busy"},    busy,    0);
    chk({v.name, ".imemreq"}, imem_req, 0);
    chk({v.name, ".instret"}, instret, exp_instret);
  endtask

  vec_t vt[11];

  initial begin
    int p1, p2;
    //         name     ld st br jl jr bres idly ddly spur pc sel   rwe dreq we
    vt[0]  = mk("alu",   0, 0, 0, 0, 0, 0,  0,   0,   0,   4, 2'b00, 4, 0,  0);
    vt[1]  = mk("br_t",  0, 0, 1, 0, 0, 1,  0,   0,   0,   3, 2'b01, 0, 0,  0);
    vt[2]  = mk("br_nt", 0, 0, 1, 0, 0, 0,  0,   0,   0,   3, 2'b00, 0, 0,  0);
    vt[3]  = mk("ld_d3", 1, 0, 0, 0, 0, 0,  0,   3,   0,   8, 2'b00, 8, 4,  0);
    vt[4]  = mk("st",    0, 1, 0, 0, 0, 0,  0,   0,   0,   4, 2'b00, 0, 1,  1);
    vt[5]  = mk("ld",    1, 0, 0, 0, 0, 0,  0,   0,   0,   5, 2'b00, 5, 1,  0);
    vt[6]  = mk("jal",   0, 0, 0, 1, 0, 0,  0,   0,   0,   4, 2'b01, 4, 0,  0);
    vt[7]  = mk("jalr",  0, 0, 0, 0, 1, 0,  0,   0,   0,   4, 2'b10, 4, 0,  0);
    vt[8]  = mk("alu_i2",0, 0, 0, 0, 0, 0,  2,   0,   1,   6, 2'b00, 6, 0,  0);
    vt[9]  = mk("st_d2", 0, 1, 0, 0, 0, 0,  0,   2,   1,   6, 2'b00, 0, 3,  1);
    vt[10] = mk("ld_br", 1, 0, 1, 0, 0, 1,  0,   0,   0,   5, 2'b00, 5, 1,  0);

    rst = 1'b0; run = 1'b0; Load = 0; Store = 0; Branch = 0; next_sel = 0; Jalr = 0;
    branch_result = 0; imem_ack = 0; dmem_ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst.busy", busy, 0);
    chk("rst.strobes", {imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_en}, 0);
    chk("rst.pc_sel", pc_sel, 0);
    chk("rst.instret", instret, 0);
    chk("rst.bus_err", bus_err, 0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // Back-to-back ALU ops with run held: refetch immediately after retire.
    @(negedge clk);
    Load = 0; Store = 0; Branch = 0; next_sel = 0; Jalr = 0; branch_result = 0;
    imem_ack = 1'b1; dmem_ack = 1'b0; run = 1'b1;
    p1 = 0; p2 = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c >= 5) run = 1'b0;
      #1;
      if (pc_en) begin if (p1 == 0) p1 = c; else p2 = c; end
      if (c == 5) chk("b2b.refetch", imem_req, 1);
      if (c == 9) chk("b2b.idle", busy, 0);
    end
    exp_instret += 2;
    chk("b2b.pc1", p1, 4);
    chk("b2b.pc2", p2, 8);
    chk("b2b.instret", instret, exp_instret);

    // Reset while a load waits in MEM.
    @(negedge clk);
    Load = 1'b1; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b0;
    p1 = 0;
    for (int c = 1; c <= 20 && p1 == 0; c++) begin
      @(negedge clk);
      run = 1'b0;
      #1;
      if (dmem_req) p1 = c;
    end
    chk("mrst.reached_mem", p1, 4);
    rst = 1'b0;
    #1;
    chk("mrst.strobes", {imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_en}, 0);
    chk("mrst.busy", busy, 0);
    chk("mrst.instret", instret, 0);
    exp_instret = 0;
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; Load = 1'b0;
    run_vec(vt[0]);

`ifdef SEQ_TIMEOUT_EN
    @(negedge clk);
    imem_ack = 1'b0; run = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      run = 1'b0;
      #1;
      if (c == 16) begin
        chk("to.req16", imem_req, 1);
        chk("to.err16", bus_err, 0);
      end
      if (c == 17) begin
        chk("to.req17", imem_req, 0);
        chk("to.err17", bus_err, 1);
        chk("to.busy17", busy, 1);
      end
      if (c == 20) begin
        chk("to.err20", bus_err, 1);
        chk("to.instret", instret, exp_instret);
      end
    end
    rst = 1'b0;
    #1;
    chk("to.rst_err", bus_err, 0);
    @(negedge clk);
    rst = 1'b1;
`else
    chk("noto.bus_err", bus_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the decode/execute datapath one instruction at a time.
- Handshakes instruction and data memory, gates register-file write and PC update, and selects the next-PC source.
- Sits between the instruction/data memory interfaces and the decode stage.
- Consumes the decode stage's Load/Store/Branch/next_sel/Jalr/branch_result flags.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.
- TIMEOUT_CYCLES, 16, maximum wait cycles on a memory ack (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- run  input  1  level; 1 = execute instructions, 0 = stop at next instruction boundary.
- Load  input  1  decoded load flag.
- Store  input  1  decoded store flag.
- Branch  input  1  decoded conditional-branch flag.
- next_sel  input  1  decoded JAL flag.
- Jalr  input  1  decoded JALR flag.
- branch_result  input  1  branch condition true.
- imem_ack  input  1  instruction memory data valid.
- dmem_ack  input  1  data memory access complete.
- imem_req  output  1  instruction fetch request.
- ir_load  output  1  latch instruction register.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write.
- reg_write_en  output  1  register-file write gate.
- pc_en  output  1  PC update strobe.
- pc_sel  output  2  00 = pc+4, 01 = branch/JAL target, 10 = JALR target.
- busy  output  1  FSM not in IDLE.
- instret  output  CNT_WIDTH  retired-instruction count.
- bus_err  output  1  sticky memory-timeout flag (0 when feature absent).

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, instret=0, bus_err=0.
  - All strobes 0, pc_sel=00.
  - Reset mid-instruction abandons the instruction: no pc_en, no reg_write_en.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK (plus ERR with the optional feature).
- Strobes are combinational from the state register and the ack inputs; state, instret and bus_err are registered.
- IDLE: run=1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - imem_req=1.
  - imem_ack=1 -> ir_load=1 in the same cycle, next state DECODE.
  - Otherwise hold, with imem_req held high.
- DECODE: exactly 1 cycle (regfile read, control settle) -> EXECUTE.
- EXECUTE, exactly 1 cycle:
  - Load|Store -> MEM.
  - Branch -> retire now; pc_sel=01 if branch_result else 00.
  - Otherwise -> WRITEBACK.
- MEM:
  - dmem_req=1; dmem_we=Store.
  - Hold until dmem_ack.
  - On ack: Store -> retire; Load -> WRITEBACK.
- WRITEBACK, 1 cycle:
  - reg_write_en=1.
  - pc_sel=01 if next_sel, 10 if Jalr, else 00.
  - Retire.
- Retire cycle:
  - pc_en=1 for exactly one cycle; instret increments by 1, wrapping at 2^CNT_WIDTH.
  - Next state FETCH if run=1, else IDLE.
- pc_sel is 00 in every cycle where pc_en=0.
- Latency with zero-wait memory:
  - ALU/JAL/JALR: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- run deasserted mid-instruction: the instruction completes, then IDLE. run is sampled only in IDLE and at retire.
- An ack arriving while the matching req=0 is ignored.
- Both acks high together: only the one for the current state is used.
- Branch and Load/Store flags must be mutually exclusive; if both are set, Load/Store takes priority.
- busy=0 only in IDLE.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- When defined:
  - A wait counter clears on entry to FETCH/MEM and counts each cycle the req is high without ack.
  - On reaching TIMEOUT_CYCLES -> state ERR, req dropped, bus_err=1 (sticky).
  - ERR holds until reset; no retire, no pc_en.
- When undefined: no counter, no ERR state; bus_err tied to 0; waits are unbounded.

Decomposition:
- Package seq_pkg:
  - typedef enum logic [2:0] seq_state_t (IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, ERR=6).
  - localparams PC_PLUS4=2'b00, PC_TARGET=2'b01, PC_JALR=2'b10.
- One sub-module, seq_wait_timer (counter + compare), instantiated only under SEQ_TIMEOUT_EN.

Test Plan:
- Reset while in MEM with dmem_req=1 -> all outputs 0 immediately, instret=0, state IDLE.
- ALU instruction, run=1, imem_ack tied 1:
  - imem_req at cycle 1, ir_load at cycle 1, reg_write_en and pc_en at cycle 4, pc_sel=00.
  - instret=1 afterwards.
- Branch=1, branch_result=1 -> pc_en with pc_sel=01 in EXECUTE (cycle 3), no reg_write_en.
- Branch=1, branch_result=0 -> pc_sel=00.
- Load with dmem_ack delayed 3 cycles:
  - dmem_req high for 4 cycles, dmem_we=0.
  - reg_write_en 1 cycle after ack; total 8 cycles.
- Store: dmem_we=1, pc_en on the ack cycle, reg_write_en never 1.
- run dropped during DECODE of a JALR: the instruction retires with pc_sel=10, then IDLE, busy=0, no further imem_req.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, imem_ack held 0 -> bus_err=1 after 16 wait cycles, imem_req=0, instret unchanged until reset.
